// File: rtl/xbus_arbiter_pkg.sv
// Shared types and defaults for the xbus arbiter.
//   XB_NMASTERS / XB_TIMEOUT : default master count and BUSY timeout
//   xb_state_e               : arbiter FSM states
//   xb_req_t                 : one latched bus request (addr/we/be/wdata)
package xbus_arbiter_pkg;
  localparam int XB_NMASTERS = 2;
  localparam int XB_TIMEOUT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } xb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } xb_req_t;
endpackage

// File: rtl/xbus_arbiter_if.sv
// Master-side request/response lines plus the shared xbus lines.
//   m_req/m_addr/m_we/m_be/m_wdata : per-master request, master i in row i
//   m_ready/m_err/m_rdata          : completion back to the owning master
//   xbus_*                         : shared bus toward decoder and slaves
// Modports: slave = arbiter view, master = requesters + slaves (environment).
interface xbus_arbiter_if #(
  parameter int NMASTERS = 2
);
  logic [NMASTERS-1:0]       m_req;
  logic [NMASTERS-1:0][31:0] m_addr;
  logic [NMASTERS-1:0]       m_we;
  logic [NMASTERS-1:0][3:0]  m_be;
  logic [NMASTERS-1:0][31:0] m_wdata;
  logic [NMASTERS-1:0]       m_ready;
  logic                      m_err;
  logic [31:0]               m_rdata;
  logic                      xbus_as;
  logic [31:0]               xbus_addr;
  logic                      xbus_we;
  logic [3:0]                xbus_be;
  logic [31:0]               xbus_wdata;
  logic                      xbus_rdy;
  logic [31:0]               xbus_rdata;

  modport slave (
    input  m_req, m_addr, m_we, m_be, m_wdata, xbus_rdy, xbus_rdata,
    output m_ready, m_err, m_rdata,
           xbus_as, xbus_addr, xbus_we, xbus_be, xbus_wdata
  );

  modport master (
    output m_req, m_addr, m_we, m_be, m_wdata, xbus_rdy, xbus_rdata,
    input  m_ready, m_err, m_rdata,
           xbus_as, xbus_addr, xbus_we, xbus_be, xbus_wdata
  );
endinterface

// File: rtl/xbus_arbiter_rr_pick.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : last served index; search starts at ptr+1 and wraps
//   grant : index of the first requester found
//   valid : any request present
module xbus_arbiter_rr_pick #(
  parameter int NMASTERS = 2,
  parameter int PW       = $clog2(NMASTERS)
) (
  input  logic [NMASTERS-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [PW-1:0]       grant,
  output logic                valid
);
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = ptr;
    for (int k = 0; k < NMASTERS; k++) begin
      idx = (idx == PW'(NMASTERS - 1)) ? '0 : idx + 1'b1;
      if (!valid && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/xbus_arbiter.sv
// Round-robin arbiter / sequencer sharing one xbus between NMASTERS masters.
//   clk, rst_n : clock, async active-low reset
//   bus        : request/response and xbus lines (slave modport)
// IDLE picks a winner and latches its request onto the bus registers, BUSY
// holds the strobe until xbus_rdy or timeout, DONE pulses m_ready[owner].
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int NMASTERS = XB_NMASTERS,
  parameter int TIMEOUT  = XB_TIMEOUT
) (
  input logic           clk,
  input logic           rst_n,
  xbus_arbiter_if.slave bus
);
  localparam int PW = $clog2(NMASTERS);
  localparam int CW = $clog2(TIMEOUT);

  xb_state_e           state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  xb_req_t             breq_q, breq_d;
  logic                as_q, as_d;
  logic [NMASTERS-1:0] ready_q, ready_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [PW-1:0]       pick;
  logic                pick_vld;

  xbus_arbiter_rr_pick #(.NMASTERS(NMASTERS), .PW(PW)) u_pick (
    .req   (bus.m_req),
    .ptr   (ptr_q),
    .grant (pick),
    .valid (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    breq_d  = breq_q;
    as_d    = as_q;
    ready_d = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          breq_d  = '{addr:  bus.m_addr[pick],  we:    bus.m_we[pick],
                      be:    bus.m_be[pick],    wdata: bus.m_wdata[pick]};
          cnt_d   = '0;
          as_d    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // rdy is tested first so it wins a tie with the timeout
        if (bus.xbus_rdy) begin
          rdata_d          = breq_q.we ? '0 : bus.xbus_rdata;
          err_d            = 1'b0;
          ready_d[owner_q] = 1'b1;
          as_d             = 1'b0;
          state_d          = ST_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d          = '0;
          err_d            = 1'b1;
          ready_d[owner_q] = 1'b1;
          as_d             = 1'b0;
          state_d          = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        // the master just served drops to lowest priority
        ptr_d   = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PW'(NMASTERS - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      breq_q  <= '0;
      as_q    <= 1'b0;
      ready_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      breq_q  <= breq_d;
      as_q    <= as_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.xbus_as    = as_q;
  assign bus.xbus_addr  = breq_q.addr;
  assign bus.xbus_we    = breq_q.we;
  assign bus.xbus_be    = breq_q.be;
  assign bus.xbus_wdata = breq_q.wdata;
  assign bus.m_ready    = ready_q;
  assign bus.m_err      = err_q;
  assign bus.m_rdata    = rdata_q;
endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: reset state, read, write, timeout,
// rdy/timeout race, reset mid-BUSY and two-master contention.
module tb_xbus_arbiter;
  localparam int NM = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xbus_arbiter_if #(.NMASTERS(NM)) bus ();
  xbus_arbiter #(.NMASTERS(NM), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // per-transaction observations
  int            as_cnt, gap;
  logic [NM-1:0] got_rdy;
  logic          got_err, stable, done_ok;
  logic [31:0]   got_rdata, b_addr, b_wdata;
  logic          b_we;
  logic [3:0]    b_be;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // Acts as the slave: raises xbus_rdy in BUSY cycle `lat` (0 = never),
  // records bus fields and waits (bounded) for the m_ready pulse.
  task automatic run_txn(input int lat, input logic [31:0] rdata);
    as_cnt = 0; gap = 0; stable = 1'b1; done_ok = 1'b0;
    got_rdy = '0; got_err = 1'bx; got_rdata = 'x;
    for (int c = 0; c < 100 && !done_ok; c++) begin
      @(negedge clk);
      if (bus.m_ready != '0) begin
        got_rdy   = bus.m_ready;
        got_err   = bus.m_err;
        got_rdata = bus.m_rdata;
        bus.xbus_rdy = 1'b0;
        done_ok = 1'b1;
      end else if (bus.xbus_as) begin
        as_cnt++;
        if (as_cnt == 1) begin
          b_addr = bus.xbus_addr; b_we = bus.xbus_we;
          b_be = bus.xbus_be; b_wdata = bus.xbus_wdata;
        end else if (bus.xbus_addr !== b_addr || bus.xbus_we !== b_we ||
                     bus.xbus_be !== b_be || bus.xbus_wdata !== b_wdata) begin
          stable = 1'b0;
        end
        bus.xbus_rdy   = (as_cnt == lat);
        bus.xbus_rdata = rdata;
      end else begin
        if (as_cnt == 0) gap++;
        bus.xbus_rdy = 1'b0;
      end
    end
    chk("txn_done", 64'(done_ok), 64'd1);
  endtask

  initial begin
    bus.m_req = '0; bus.m_addr = '0; bus.m_we = '0; bus.m_be = '0;
    bus.m_wdata = '0; bus.xbus_rdy = 1'b0; bus.xbus_rdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_as",    64'(bus.xbus_as),    64'd0);
    chk("rst_addr",  64'(bus.xbus_addr),  64'd0);
    chk("rst_we",    64'(bus.xbus_we),    64'd0);
    chk("rst_be",    64'(bus.xbus_be),    64'd0);
    chk("rst_wdata", 64'(bus.xbus_wdata), 64'd0);
    chk("rst_ready", 64'(bus.m_ready),    64'd0);
    chk("rst_err",   64'(bus.m_err),      64'd0);
    chk("rst_rdata", 64'(bus.m_rdata),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read, rdy in 2nd BUSY cycle
    bus.m_req = 2'b01; bus.m_addr[0] = 32'h8000_0010; bus.m_we[0] = 1'b0;
    run_txn(2, 32'hDEAD_BEEF);
    bus.m_req = '0;
    chk("rd_as_cnt", 64'(as_cnt),    64'd2);
    chk("rd_addr",   64'(b_addr),    64'h8000_0010);
    chk("rd_we",     64'(b_we),      64'd0);
    chk("rd_ready",  64'(got_rdy),   64'b01);
    chk("rd_rdata",  64'(got_rdata), 64'hDEAD_BEEF);
    chk("rd_err",    64'(got_err),   64'd0);
    @(negedge clk);
    chk("rd_pulse1", 64'(bus.m_ready), 64'd0);
    chk("rd_as_lo",  64'(bus.xbus_as), 64'd0);

    // write from master 1; rdata driven nonzero must come back as zero
    bus.m_req = 2'b10; bus.m_addr[1] = 32'h1000_0004; bus.m_we[1] = 1'b1;
    bus.m_be[1] = 4'b0011; bus.m_wdata[1] = 32'h1234_5678;
    run_txn(3, 32'hFFFF_FFFF);
    bus.m_req = '0; bus.m_we[1] = 1'b0;
    chk("wr_as_cnt", 64'(as_cnt),    64'd3);
    chk("wr_addr",   64'(b_addr),    64'h1000_0004);
    chk("wr_we",     64'(b_we),      64'd1);
    chk("wr_be",     64'(b_be),      64'b0011);
    chk("wr_wdata",  64'(b_wdata),   64'h1234_5678);
    chk("wr_stable", 64'(stable),    64'd1);
    chk("wr_ready",  64'(got_rdy),   64'b10);
    chk("wr_rdata",  64'(got_rdata), 64'd0);
    chk("wr_err",    64'(got_err),   64'd0);

    // timeout: master 1, no slave answers
    bus.m_req = 2'b10; bus.m_addr[1] = 32'h2000_0000;
    run_txn(0, 32'h5555_5555);
    bus.m_req = '0;
    chk("to_as_cnt", 64'(as_cnt),    64'(TO));
    chk("to_ready",  64'(got_rdy),   64'b10);
    chk("to_err",    64'(got_err),   64'd1);
    chk("to_rdata",  64'(got_rdata), 64'd0);

    // race: rdy in the last BUSY cycle (counter at TIMEOUT-1)
    bus.m_req = 2'b01; bus.m_addr[0] = 32'h0000_0040;
    run_txn(TO, 32'hCAFE_F00D);
    bus.m_req = '0;
    chk("race_as_cnt", 64'(as_cnt),    64'(TO));
    chk("race_ready",  64'(got_rdy),   64'b01);
    chk("race_err",    64'(got_err),   64'd0);
    chk("race_rdata",  64'(got_rdata), 64'hCAFE_F00D);

    // reset asserted mid-BUSY
    @(negedge clk);
    bus.m_req = 2'b10; bus.m_addr[1] = 32'h3000_0008;
    repeat (4) @(negedge clk);
    chk("mid_as_pre", 64'(bus.xbus_as), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_as",    64'(bus.xbus_as),   64'd0);
    chk("mid_addr",  64'(bus.xbus_addr), 64'd0);
    chk("mid_ready", 64'(bus.m_ready),   64'd0);
    repeat (2) @(negedge clk);
    chk("mid_ready2", 64'(bus.m_ready), 64'd0);
    rst_n = 1'b1;

    // contention with zero-wait slave: grants 0,1,0,1
    bus.m_req = 2'b11; bus.m_addr[0] = 32'h0000_1000;
    for (int t = 0; t < 4; t++) begin
      run_txn(1, 32'(t));
      chk($sformatf("ct%0d_ready", t), 64'(got_rdy), (t % 2 == 0) ? 64'b01 : 64'b10);
      chk($sformatf("ct%0d_as", t), 64'(as_cnt), 64'd1);
      if (t > 0) chk($sformatf("ct%0d_gap", t), 64'(gap), 64'd1);
    end
    bus.m_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
